conv_mac_engine: RTL and testbench
==================================

# conv_mac_engine

Sequential, parametrised convolution engine for the coprocessor datapath. It computes the dot product of an N×N pixel window and an N×N signed kernel, with N selectable from 2 to MAX_N. It uses one multiply-accumulate per clock, so it needs a single multiplier instead of MAX_N² parallel ones. Two selectable output modes are provided: pixel-clamp and signed-saturate. A start/busy/done handshake lets the coprocessor control FSM issue one window per request.

## Interface
- PIX_W, 8, pixel element width (unsigned)
- KER_W, 8, kernel element width (signed, two's complement)
- MAX_N, 5, maximum window side; operands packed as MAX_N×MAX_N elements
- ACC_W, 22, accumulator width (signed); must be ≥ PIX_W+KER_W+ceil(log2(MAX_N²))+1
- OUT_W, 16, result width (signed)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request; accepted only when busy=0
- matrix_size  input  2  window side N = matrix_size+2 (00=2×2 … 11=5×5); values giving N>MAX_N are treated as N=MAX_N
- mode  input  1  0 = pixel-clamp to [0, 2^PIX_W−1]; 1 = signed saturate to OUT_W range
- pixel  input  MAX_N*MAX_N*PIX_W  element (r,c) at bits [(r*MAX_N+c)*PIX_W +: PIX_W]
- kernel  input  MAX_N*MAX_N*KER_W  same layout, signed
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse, result valid
- result  output  OUT_W  final value; held until the next done
- overflow  output  1  high when the final value was clamped or saturated; updated together with result

## Operation
- FSM states: IDLE, MAC, FINISH.
- IDLE:
  - On start=1, latch pixel, kernel, matrix_size and mode into internal registers.
  - Clear the accumulator, set row=col=0 and go to MAC.
  - Inputs may change freely after the accept edge.
- MAC:
  - Each cycle: acc ← acc + $signed({1'b0,pix[r][c]}) × $signed(ker[r][c]), where index = r*MAX_N+c.
  - Only r,c < N are visited; all elements outside the N×N region are ignored whatever their value.
  - Column increments first. At c=N−1, c wraps to 0 and r increments.
  - After element (N−1,N−1), go to FINISH.
- FINISH:
  - Mode 0: acc<0 → result=0, overflow=1. acc>2^PIX_W−1 → result=2^PIX_W−1, overflow=1. Otherwise result=acc, zero-extended, overflow=0.
  - Mode 1: acc>2^(OUT_W−1)−1 → max positive, overflow=1. acc<−2^(OUT_W−1) → min negative, overflow=1. Otherwise result=acc truncated losslessly to OUT_W, overflow=0.
  - Pulse done for one cycle and return to IDLE.
- With the default widths the accumulator never wraps: worst case 25×255×128 fits in 22 bits signed.
- start while busy=1 is ignored; nothing is queued.

## Timing
- Reset values: busy=0, done=0, result=0, overflow=0, state IDLE, accumulator 0.
- Accept edge E0: start sampled high in IDLE; busy=1 after E0.
- Edges E1..E(N²): one MAC each.
- Edge E(N²+1): result and overflow registered, done=1, busy=0.
- Latency from accept edge to done: N²+1 cycles (2×2: 5, 3×3: 10, 4×4: 17, 5×5: 26).
- done is high for exactly one cycle. start=1 in that same cycle is accepted, giving back-to-back operation with no idle gap.
- Reset asserted mid-operation: immediately abort, return to IDLE, force all outputs to reset values; no done is produced for the aborted request.
- Changes to matrix_size or mode while busy have no effect on the current request.

## Test plan
- 2×2, mode 0, all pixels 10, all kernel 1, all other elements 0xFF → done 5 cycles after accept, result=40, overflow=0 (out-of-window elements ignored).
- 5×5, all pixels 255, all kernel 127 (sum 809625):
  - mode 0 → result=255, overflow=1, latency 26.
  - mode 1 → result=32767, overflow=1.
- 3×3, pixels 100, kernel −1 (0xFF), sum −900:
  - mode 0 → result=0, overflow=1.
  - mode 1 → result=0xFC7C (−900), overflow=0, latency 10.
- 4×4 identity-like kernel (ker[0][0]=2, others 0), pixel[0][0]=60 → result=120. Start pulsed again on cycles 3 and 8 while busy → ignored, exactly one done.
- Back-to-back: second start in the done cycle → second done exactly N²+1 cycles later, and the first result holds until then.
- Reset asserted on the 7th MAC cycle of a 5×5 job → busy, done, result and overflow go to 0 immediately; no done follows; a new 2×2 job then completes normally.

Source files
------------

// File: rtl/conv_mac_engine.sv
// Sequential N x N convolution dot product, one MAC per clock.
// Clamps to pixel range or saturates to signed OUT_W on completion.
module conv_mac_engine #(
  parameter int PIX_W = 8,
  parameter int KER_W = 8,
  parameter int MAX_N = 5,
  parameter int ACC_W = 22,
  parameter int OUT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   matrix_size,
  input  logic                         mode,
  input  logic [MAX_N*MAX_N*PIX_W-1:0] pixel,
  input  logic [MAX_N*MAX_N*KER_W-1:0] kernel,
  output logic                         busy,
  output logic                         done,
  output logic [OUT_W-1:0]             result,
  output logic                         overflow
);

  localparam int NE = MAX_N * MAX_N;
  localparam int NW = $clog2(MAX_N + 1);
  localparam int IW = $clog2(NE);
  localparam int PW = PIX_W + KER_W + 1;

  localparam logic signed [ACC_W-1:0] PIX_MAX =
    ACC_W'((1 << PIX_W) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    ACC_W'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FINISH
  } state_e;

  state_e                   state_q;
  logic [PIX_W-1:0]         pix_q [NE];
  logic [KER_W-1:0]         ker_q [NE];
  logic [NW-1:0]            n_q;
  logic [NW-1:0]            r_q;
  logic [NW-1:0]            c_q;
  logic                     mode_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     busy_q;
  logic                     done_q;
  logic [OUT_W-1:0]         res_q;
  logic                     ovf_q;

  logic [NW-1:0]            n_d;
  logic [IW-1:0]            idx;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic [OUT_W-1:0]         res_d;
  logic                     ovf_d;

  always_comb begin
    int n_int;
    n_int = int'(matrix_size) + 2;
    if (n_int > MAX_N) n_int = MAX_N;
    n_d = NW'(n_int);
  end

  // Single shared multiplier; pixel is zero-extended to stay unsigned.
  always_comb begin
    idx   = IW'(int'(r_q) * MAX_N + int'(c_q));
    prod  = $signed({1'b0, pix_q[idx]}) * $signed(ker_q[idx]);
    acc_d = acc_q + ACC_W'(prod);
  end

  always_comb begin
    res_d = OUT_W'(acc_q);
    ovf_d = 1'b0;
    if (!mode_q) begin
      if (acc_q < 0) begin
        res_d = '0;
        ovf_d = 1'b1;
      end else if (acc_q > PIX_MAX) begin
        res_d = OUT_W'(PIX_MAX);
        ovf_d = 1'b1;
      end
    end else begin
      if (acc_q > OUT_MAX) begin
        res_d = OUT_W'(OUT_MAX);
        ovf_d = 1'b1;
      end else if (acc_q < OUT_MIN) begin
        res_d = OUT_W'(OUT_MIN);
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NE; i++) begin
        pix_q[i] <= '0;
        ker_q[i] <= '0;
      end
      n_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NE; i++) begin
              pix_q[i] <= pixel[i*PIX_W +: PIX_W];
              ker_q[i] <= kernel[i*KER_W +: KER_W];
            end
            n_q     <= n_d;
            mode_q  <= mode;
            acc_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (c_q == n_q - NW'(1)) begin
            c_q <= '0;
            if (r_q == n_q - NW'(1)) state_q <= FINISH;
            else r_q <= r_q + NW'(1);
          end else begin
            c_q <= c_q + NW'(1);
          end
        end
        FINISH: begin
          res_q   <= res_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: latency, clamp/saturate,
// busy-ignore, back-to-back and mid-job reset.
module tb_conv_mac_engine;

  localparam int PIX_W = 8;
  localparam int KER_W = 8;
  localparam int MAX_N = 5;
  localparam int ACC_W = 22;
  localparam int OUT_W = 16;
  localparam int NE    = MAX_N * MAX_N;

  typedef logic [NE*PIX_W-1:0] pvec_t;
  typedef logic [NE*KER_W-1:0] kvec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       matrix_size = 2'd0;
  logic             mode = 1'b0;
  pvec_t            pixel = '0;
  kvec_t            kernel = '0;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] result;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  conv_mac_engine #(
    .PIX_W(PIX_W), .KER_W(KER_W), .MAX_N(MAX_N),
    .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .matrix_size(matrix_size), .mode(mode),
    .pixel(pixel), .kernel(kernel),
    .busy(busy), .done(done),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window r,c < n gets inv, everything else gets outv.
  function automatic pvec_t mk_pix(int n, logic [7:0] inv,
                                   logic [7:0] outv);
    pvec_t v;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        v[(r*MAX_N+c)*PIX_W +: PIX_W] =
          (r < n && c < n) ? inv : outv;
    return v;
  endfunction

  function automatic kvec_t mk_ker(int n, logic [7:0] inv,
                                   logic [7:0] outv);
    kvec_t v;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        v[(r*MAX_N+c)*KER_W +: KER_W] =
          (r < n && c < n) ? inv : outv;
    return v;
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic start_job(input logic [1:0] ms, input logic md,
                           input pvec_t pv, input kvec_t kv);
    matrix_size = ms;
    mode        = md;
    pixel       = pv;
    kernel      = kv;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    pixel       = '1;
    kernel      = '1;
  endtask

  // Cycles from accept edge to done; -1 if the bound expires.
  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 2x2 mode 0, out-of-window 0xFF ignored
    start_job(2'd0, 1'b0, mk_pix(2, 8'd10, 8'hFF),
              mk_ker(2, 8'd1, 8'hFF));
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(40, lat);
    check("t1_lat", 32'(lat), 32'd5);
    check("t1_result", 32'(result), 32'd40);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 32'(done), 32'd0);

    // 5x5 all 255 x 127, mode 0 clamp
    start_job(2'd3, 1'b0, mk_pix(5, 8'd255, 8'd0),
              mk_ker(5, 8'd127, 8'd0));
    wait_done(40, lat);
    check("t2_lat", 32'(lat), 32'd26);
    check("t2_result", 32'(result), 32'd255);
    check("t2_ovf", 32'(overflow), 32'd1);

    // same, mode 1 saturate
    start_job(2'd3, 1'b1, mk_pix(5, 8'd255, 8'd0),
              mk_ker(5, 8'd127, 8'd0));
    wait_done(40, lat);
    check("t3_lat", 32'(lat), 32'd26);
    check("t3_result", 32'(result), 32'd32767);
    check("t3_ovf", 32'(overflow), 32'd1);

    // 3x3 100 x -1, mode 0 -> clamp at 0
    start_job(2'd1, 1'b0, mk_pix(3, 8'd100, 8'd77),
              mk_ker(3, 8'hFF, 8'h55));
    wait_done(40, lat);
    check("t4_lat", 32'(lat), 32'd10);
    check("t4_result", 32'(result), 32'd0);
    check("t4_ovf", 32'(overflow), 32'd1);

    // 3x3, mode 1 -> -900
    start_job(2'd1, 1'b1, mk_pix(3, 8'd100, 8'd77),
              mk_ker(3, 8'hFF, 8'h55));
    wait_done(40, lat);
    check("t5_lat", 32'(lat), 32'd10);
    check("t5_result", 32'(result), 32'hFC7C);
    check("t5_ovf", 32'(overflow), 32'd0);

    // 4x4 single tap, start pulses while busy ignored
    begin
      pvec_t pv;
      kvec_t kv;
      pv = mk_pix(5, 8'hFF, 8'hFF);
      pv[0 +: PIX_W] = 8'd60;
      kv = mk_ker(4, 8'd0, 8'h7F);
      kv[0 +: KER_W] = 8'd2;
      start_job(2'd2, 1'b0, pv, kv);
    end
    ndone = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3 || i == 8) begin
        start = 1'b1;
        matrix_size = 2'd0;
        mode = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    check("t6_lat", 32'(lat), 32'd17);
    check("t6_ndone", 32'(ndone), 32'd1);
    check("t6_result", 32'(result), 32'd120);
    check("t6_ovf", 32'(overflow), 32'd0);

    // back-to-back: 2x2 (40) then 3x3 mode 1 (-900)
    start_job(2'd0, 1'b0, mk_pix(2, 8'd10, 8'hFF),
              mk_ker(2, 8'd1, 8'hFF));
    wait_done(40, lat);
    check("t7a_lat", 32'(lat), 32'd5);
    check("t7a_result", 32'(result), 32'd40);
    start_job(2'd1, 1'b1, mk_pix(3, 8'd100, 8'd0),
              mk_ker(3, 8'hFF, 8'd0));
    check("t7b_busy", 32'(busy), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("t7_hold", 32'(result), 32'd40);
    wait_done(40, lat);
    check("t7b_lat", 32'(lat), 32'd2);
    check("t7b_result", 32'(result), 32'hFC7C);

    // reset during the 7th MAC cycle of a 5x5 job
    start_job(2'd3, 1'b1, mk_pix(5, 8'd1, 8'd0),
              mk_ker(5, 8'd1, 8'd0));
    repeat (6) @(posedge clk);
    #1;
    check("t8_busy_pre", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_done", 32'(done), 32'd0);
    check("t8_result", 32'(result), 32'd0);
    check("t8_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("t8_nodone", 32'(ndone), 32'd0);
    start_job(2'd0, 1'b0, mk_pix(2, 8'd10, 8'hFF),
              mk_ker(2, 8'd1, 8'hFF));
    wait_done(40, lat);
    check("t8_lat", 32'(lat), 32'd5);
    check("t8_result2", 32'(result), 32'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
